// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch PC stage.
//   PC_SRC_*  : next-PC select codes driven by the branch resolver
//   RESET_PC  : architectural PC loaded on reset
//   NOP_INST  : instruction held in the decode register after reset (addi x0,x0,0)
//   ifu_state_e : fetch/execute loop states
package cpu_pkg;

  localparam logic [1:0] PC_SRC_SEQ  = 2'b00;
  localparam logic [1:0] PC_SRC_JAL  = 2'b01;
  localparam logic [1:0] PC_SRC_JALR = 2'b10;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    FAULT = 2'd3
  } ifu_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC generator.
//   pc       : PC of the executing instruction
//   pc_src   : 00 seq, 01 pc+imm, 10 rs1+imm (bit0 cleared), 11 treated as seq
//   imm      : sign-extended immediate
//   rs1_data : rs1 register value
//   nxt      : computed next PC (all adds wrap modulo 2^XLEN)
//   misalign : nxt is not 4-byte aligned
module next_pc_calc
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] nxt,
  output logic            misalign
);

  logic [XLEN-1:0] seq_tgt;
  logic [XLEN-1:0] jal_tgt;
  logic [XLEN-1:0] jalr_sum;

  // Two's-complement addition handles the signed immediate; overflow wraps silently.
  assign seq_tgt  = pc + XLEN'(4);
  assign jal_tgt  = pc + imm;
  assign jalr_sum = rs1_data + imm;

  always_comb begin
    nxt = seq_tgt;
    case (pc_src)
      PC_SRC_JAL:  nxt = jal_tgt;
      PC_SRC_JALR: nxt = {jalr_sum[XLEN-1:1], 1'b0};
      default:     nxt = seq_tgt;
    endcase
  end

  // Bit 1 can still be set after JALR clears bit 0, and JAL can land anywhere.
  assign misalign = |nxt[1:0];

endmodule

// File: rtl/ifu_pc_fsm.sv
// Instruction-fetch PC stage: multi-cycle fetch/execute loop.
// Holds the architectural PC, fetches over a valid/ready request channel,
// presents the instruction to decode until execute commits, then computes
// the next PC. Misaligned targets and bus errors park the block in a sticky
// FAULT state that only reset leaves.
//   clk, rst        : clock, synchronous active-high reset
//   pc_src/imm/rs1_data/commit : next-PC operands from execute/branch resolver
//   imem_req_*      : fetch request (valid/ready), address is the current PC
//   imem_resp_*     : fetch response data and bus-error flag
//   inst/inst_valid/pc : instruction and its PC presented to decode
//   fault/fault_pc  : sticky fault flag and offending address
module ifu_pc_fsm
  import cpu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      pc_src,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_data,
  input  logic            commit,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            imem_resp_err,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic [XLEN-1:0] pc,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  ifu_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic [XLEN-1:0] nxt;
  logic            misalign;

  next_pc_calc #(
    .XLEN (XLEN)
  ) u_next_pc_calc (
    .pc       (pc_q),
    .pc_src   (pc_src),
    .imm      (imm),
    .rs1_data (rs1_data),
    .nxt      (nxt),
    .misalign (misalign)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= REQ;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    case (state_q)
      // Address is the held PC, so it stays stable until the handshake completes.
      REQ: begin
        if (imem_req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            state_d    = FAULT;
          end else begin
            inst_d  = imem_resp_data;
            state_d = EXEC;
          end
        end
      end
      // A faulting target leaves pc pointing at the instruction that produced it.
      EXEC: begin
        if (commit) begin
          if (misalign) begin
            fault_d    = 1'b1;
            fault_pc_d = nxt;
            state_d    = FAULT;
          end else begin
            pc_d    = nxt;
            state_d = REQ;
          end
        end
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // Handshake-facing flags decode from state only: no input-to-output paths.
  assign imem_req_valid = (state_q == REQ);
  assign inst_valid     = (state_q == EXEC);
  assign imem_req_addr  = pc_q;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign fault          = fault_q;
  assign fault_pc       = fault_pc_q;

endmodule

// File: tb/tb_ifu_pc_fsm.sv
module tb_ifu_pc_fsm;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic [31:0] imm;
  logic [31:0] rs1_data;
  logic        commit;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_resp_err;
  logic [31:0] inst;
  logic        inst_valid;
  logic [31:0] pc;
  logic        fault;
  logic [31:0] fault_pc;

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model state: architectural PC the bench expects.
  logic [31:0] mpc;

  ifu_pc_fsm #(
    .XLEN     (32),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_src          (pc_src),
    .imm             (imm),
    .rs1_data        (rs1_data),
    .commit          (commit),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .imem_resp_err   (imem_resp_err),
    .inst            (inst),
    .inst_valid      (inst_valid),
    .pc              (pc),
    .fault           (fault),
    .fault_pc        (fault_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Next PC from the architectural rules: seq, pc+imm, (rs1+imm) with bit0 cleared.
  function automatic logic [31:0] model_next(input logic [1:0] src, input logic [31:0] cur,
                                             input logic [31:0] im, input logic [31:0] r1);
    case (src)
      2'b01:   return cur + im;
      2'b10:   return (r1 + im) & 32'hFFFF_FFFE;
      default: return cur + 32'd4;
    endcase
  endfunction

  task automatic idle_inputs();
    commit          = 1'b0;
    pc_src          = 2'b00;
    imm             = '0;
    rs1_data        = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    imem_resp_err   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mpc = RST_PC;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_req_addr", imem_req_addr, RST_PC);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", pc, RST_PC);
  endtask

  // One fetch: hold off ready for rdly cycles, then wait wdly idle cycles for
  // the response. Stray commits and responses in REQ/WAIT must be ignored.
  task automatic fetch(input logic [31:0] data, input int rdly, input int wdly, input bit err);
    for (int i = 0; i <= rdly; i++) begin
      chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("req_addr", imem_req_addr, mpc);
      chk("req_inst_valid", {31'd0, inst_valid}, 32'd0);
      imem_req_ready  = (i == rdly);
      commit          = 1'($urandom % 2);
      pc_src          = 2'($urandom % 4);
      imm             = $urandom;
      imem_resp_valid = 1'($urandom % 2);
      imem_resp_data  = $urandom;
      imem_resp_err   = 1'($urandom % 2);
      @(negedge clk);
    end
    imem_req_ready = 1'b0;
    for (int i = 0; i <= wdly; i++) begin
      chk("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("wait_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("wait_pc", pc, mpc);
      imem_resp_valid = (i == wdly);
      imem_resp_data  = (i == wdly) ? data : $urandom;
      imem_resp_err   = (i == wdly) ? err : 1'b0;
      commit          = 1'($urandom % 2);
      pc_src          = 2'($urandom % 4);
      imm             = $urandom;
      @(negedge clk);
    end
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    commit          = 1'b0;
    if (err) begin
      chk("err_fault", {31'd0, fault}, 32'd1);
      chk("err_fault_pc", fault_pc, mpc);
      chk("err_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("err_inst_valid", {31'd0, inst_valid}, 32'd0);
    end else begin
      chk("fetch_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("fetch_inst", inst, data);
      chk("fetch_pc", pc, mpc);
      chk("fetch_fault", {31'd0, fault}, 32'd0);
    end
  endtask

  // Execute: idle cycles in EXEC, then one commit. Returns whether it faulted.
  task automatic exec(input logic [1:0] src, input logic [31:0] im, input logic [31:0] r1,
                      input int idle, output bit faulted);
    logic [31:0] nxt;
    logic [31:0] held_inst;
    held_inst = inst;
    for (int i = 0; i <= idle; i++) begin
      chk("exec_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("exec_pc", pc, mpc);
      chk("exec_inst", inst, held_inst);
      commit   = (i == idle);
      pc_src   = (i == idle) ? src : 2'($urandom % 4);
      imm      = (i == idle) ? im : $urandom;
      rs1_data = (i == idle) ? r1 : $urandom;
      @(negedge clk);
    end
    commit = 1'b0;
    nxt = model_next(src, mpc, im, r1);
    if (nxt[1:0] != 2'b00) begin
      faulted = 1'b1;
      chk("mis_fault", {31'd0, fault}, 32'd1);
      chk("mis_fault_pc", fault_pc, nxt);
      chk("mis_pc_kept", pc, mpc);
      chk("mis_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("mis_inst_valid", {31'd0, inst_valid}, 32'd0);
    end else begin
      faulted = 1'b0;
      mpc = nxt;
      chk("commit_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("commit_req_addr", imem_req_addr, mpc);
      chk("commit_inst_valid", {31'd0, inst_valid}, 32'd0);
    end
  endtask

  // FAULT must hold against any input activity.
  task automatic fault_hold(input logic [31:0] exp_fpc, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      commit          = 1'($urandom % 2);
      pc_src          = 2'($urandom % 4);
      imem_req_ready  = 1'($urandom % 2);
      imem_resp_valid = 1'($urandom % 2);
      imem_resp_err   = 1'($urandom % 2);
      imem_resp_data  = $urandom;
      @(negedge clk);
      chk("hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
      chk("hold_inst_valid", {31'd0, inst_valid}, 32'd0);
      chk("hold_fault", {31'd0, fault}, 32'd1);
      chk("hold_fault_pc", fault_pc, exp_fpc);
    end
    idle_inputs();
  endtask

  initial begin
    bit          f;
    logic [31:0] fpc;
    logic [31:0] rim;
    logic [31:0] rr1;
    logic [1:0]  rsrc;
    rst = 1'b1;
    idle_inputs();

    // Basic fetch: ready at cycle 1, response at cycle 3.
    do_reset();
    fetch(32'h0050_0093, 0, 1, 1'b0);
    exec(2'b00, 32'd0, 32'd0, 2, f);
    chk("seq_addr", imem_req_addr, 32'h8000_0004);
    fetch(32'h0000_0013, 3, 0, 1'b0);

    // JAL to 0x80000010, then back by -8, then JALR with bit0 cleared.
    exec(2'b01, 32'h0000_000C, 32'd0, 0, f);
    chk("jal_pc", mpc, 32'h8000_0010);
    fetch(32'h1111_1111, 1, 2, 1'b0);
    exec(2'b01, 32'hFFFF_FFF8, 32'd0, 1, f);
    chk("jal_back_addr", imem_req_addr, 32'h8000_0008);
    fetch(32'h2222_2222, 0, 0, 1'b0);
    exec(2'b10, 32'd4, 32'h8000_1001, 0, f);
    chk("jalr_addr", imem_req_addr, 32'h8000_1004);
    fetch(32'h3333_3333, 0, 0, 1'b0);
    exec(2'b11, 32'h100, 32'd0, 0, f);
    chk("reserved_seq_addr", imem_req_addr, 32'h8000_1008);

    // Misaligned JAL target faults; nothing leaves FAULT except reset.
    do_reset();
    fetch(32'h0020_006F, 0, 0, 1'b0);
    exec(2'b01, 32'd2, 32'd0, 0, f);
    fault_hold(32'h8000_0002, 5);

    // Bus error on the response.
    do_reset();
    fetch(32'hDEAD_BEEF, 2, 1, 1'b1);
    fault_hold(RST_PC, 3);

    // Reset in WAIT, then a stale response arrives while back in REQ.
    do_reset();
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    chk("wait_entered", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst             = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD0_BAD0;
    chk("rstw_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rstw_addr", imem_req_addr, RST_PC);
    @(negedge clk);
    imem_resp_valid = 1'b0;
    chk("stale_inst", inst, NOP);
    chk("stale_inst_valid", {31'd0, inst_valid}, 32'd0);
    mpc = RST_PC;
    fetch(32'h0010_0113, 0, 0, 1'b0);

    // Reset and commit together: reset wins.
    rst      = 1'b1;
    commit   = 1'b1;
    pc_src   = 2'b01;
    imm      = 32'h100;
    @(negedge clk);
    rst    = 1'b0;
    commit = 1'b0;
    chk("rstc_pc", pc, RST_PC);
    chk("rstc_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rstc_inst", inst, NOP);
    mpc = RST_PC;

    // Wrap-around from 0xFFFFFFFC.
    fetch(32'h0000_0067, 0, 0, 1'b0);
    exec(2'b10, 32'd4, 32'hFFFF_FFF8, 0, f);
    chk("wrap_pre", imem_req_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0013, 0, 0, 1'b0);
    exec(2'b00, 32'd0, 32'd0, 0, f);
    chk("wrap_addr", imem_req_addr, 32'h0000_0000);

    // Randomized fetch/execute loop.
    do_reset();
    for (int it = 0; it < 60; it++) begin
      if ($urandom % 12 == 0) begin
        fetch($urandom, int'($urandom % 4), int'($urandom % 4), 1'b1);
        fault_hold(mpc, 2);
        do_reset();
      end else begin
        fetch($urandom, int'($urandom % 4), int'($urandom % 4), 1'b0);
        rsrc = 2'($urandom % 4);
        rim  = $urandom & 32'h0000_0FFC;
        if ($urandom % 2 == 1) rim = -rim;
        if ($urandom % 8 == 0) rim = rim | 32'd2;
        rr1 = ($urandom & 32'hFFFF_FFFC) | 32'($urandom % 2);
        if ($urandom % 8 == 0) rr1 = rr1 | 32'd2;
        fpc = model_next(rsrc, mpc, rim, rr1);
        exec(rsrc, rim, rr1, int'($urandom % 3), f);
        if (f) begin
          fault_hold(fpc, 2);
          do_reset();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ifu_pc_fsm.md
Name: ifu_pc_fsm

Overview:
- Instruction-fetch PC stage that sits directly downstream of the branch resolver. It consumes the 2-bit pc_src select plus imm/rs1 operands and holds the architectural PC.
- Issues fetch requests to instruction memory over a valid/ready handshake and presents the fetched instruction to decode.
- Waits for execute to signal commit before computing and fetching the next PC.
- Turns the single-cycle core into a multi-cycle fetch/execute loop that tolerates variable memory latency.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h8000_0000, PC loaded on reset.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- pc_src  in  2  next-PC select from branch resolver: 00 seq, 01 pc+imm, 10 rs1+imm, 11 reserved
- imm  in  XLEN  sign-extended immediate of current instruction
- rs1_data  in  XLEN  rs1 register value
- commit  in  1  execute finished current instruction; pc_src/imm/rs1_data valid this cycle
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  XLEN  fetch address
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  fetch data valid
- imem_resp_data  in  32  fetched instruction
- imem_resp_err  in  1  bus error on this response
- inst  out  32  held instruction to decode
- inst_valid  out  1  inst/pc valid, instruction executing
- pc  out  XLEN  PC of the instruction in inst
- fault  out  1  sticky: misaligned target or fetch error
- fault_pc  out  XLEN  offending address

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high. Reset sets pc=RESET_PC, state=REQ, inst=32'h0000_0013 (nop), inst_valid=0, fault=0, fault_pc=0.
- imem_req_valid comes directly from state, so it is 1 in the first cycle after rst deasserts.
- States: REQ, WAIT, EXEC, FAULT.
- REQ:
  - imem_req_valid=1 and imem_req_addr=pc.
  - Addr is held stable until a cycle with imem_req_ready=1; the next state is then WAIT.
  - imem_resp_valid is ignored in REQ.
- WAIT:
  - On imem_resp_valid=1 with imem_resp_err=0: inst<=imem_resp_data, go to EXEC.
  - On imem_resp_valid=1 with imem_resp_err=1: fault<=1, fault_pc<=pc, go to FAULT.
  - The minimum fetch latency is therefore 2 cycles, request accept to inst_valid.
- EXEC:
  - inst_valid=1, and inst and pc are stable.
  - commit is sampled only in EXEC and ignored in every other state.
  - On commit, compute nxt:
    - 00: pc+4
    - 01: pc+imm
    - 10: (rs1_data+imm) & ~1
    - 11: pc+4 (reserved; treated as sequential)
  - All adds are modulo 2^XLEN; wrap-around is silent.
  - If nxt[1:0]!=0: fault<=1, fault_pc<=nxt, go to FAULT, and pc is not updated.
  - Otherwise pc<=nxt and go to REQ. The new request is issued in the next cycle.
- FAULT: all outputs hold, with imem_req_valid=0 and inst_valid=0. Only rst exits FAULT.
- Reset mid-operation:
  - Any state returns to REQ at RESET_PC.
  - An outstanding response is discarded, because imem shares rst.
- Simultaneous rst and commit: rst wins.
- Output registration: inst_valid and imem_req_valid are decoded from state only, with no combinational path from inputs.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_SRC_SEQ=2'b00, PC_SRC_JAL=2'b01, PC_SRC_JALR=2'b10
  - RESET_PC
  - NOP_INST=32'h0000_0013
  - the state enum {REQ,WAIT,EXEC,FAULT}
- Sub-module next_pc_calc: combinational; takes pc, pc_src, imm, rs1_data; outputs nxt and misalign.

Test Plan:
- Reset then imem_req_ready=1 at cycle 1 and resp at cycle 3 with data 32'h00500093 -> req_addr=0x80000000; inst_valid=1 at cycle 4 with inst=0x00500093 and pc=0x80000000.
- Sequential commit with pc_src=00 -> next req_addr=0x80000004; req_ready held 0 for 3 cycles -> addr stable, single accept.
- pc_src=01, imm=-8 at pc=0x80000010 -> next pc=0x80000008. pc_src=10, rs1=0x80001001, imm=4 -> pc=0x80001004 (bit0 cleared).
- pc_src=01, imm=2 at pc=0x80000000 -> fault=1, fault_pc=0x80000002, no further imem_req_valid until rst.
- imem_resp_err=1 in WAIT -> fault=1, fault_pc=pc. commit pulsed in REQ/WAIT -> ignored, pc unchanged.
- rst asserted in WAIT with later stale resp_valid -> pc=0x80000000, state REQ, stale response not captured. pc=0xFFFFFFFC with seq commit -> pc wraps to 0x00000000.
